// File: rtl/regfile_debug_dumper_pkg.sv
// Shared types and constants for the register-file debug dumper.
// Optional index header per register is enabled with DUMPER_INDEX_HEADER_EN.
package regfile_debug_dumper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned SEL_W        = 5;
  localparam int unsigned BYTE_W       = 8;
  localparam logic [2:0]  HDR_PAD      = 3'b000;

  function automatic int unsigned bytes_per_reg(input int unsigned width);
    return width / BYTE_W;
  endfunction

  // Header byte announcing which register the following data bytes belong to
  function automatic logic [BYTE_W-1:0] header_byte(input logic [SEL_W-1:0] idx);
    return {HDR_PAD, idx};
  endfunction

endpackage

// File: rtl/regfile_debug_dumper_byte_serializer.sv
// Loads a multi-byte word and emits it MSB byte first on a valid/ready byte stream.
module regfile_debug_dumper_byte_serializer
  import regfile_debug_dumper_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [NBYTES*BYTE_W-1:0] load_data,
  input  logic                     tx_ready,
  output logic [BYTE_W-1:0]        tx_data,
  output logic                     tx_valid,
  output logic                     last_c
);

  localparam int unsigned SW    = NBYTES * BYTE_W;
  localparam int unsigned CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [SW-1:0]    shift_q;
  logic [CNT_W-1:0] cnt_q;

  // Byte count of zero means the byte on tx_data is the final one of the word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shift_q  <= load_data;
      cnt_q    <= CNT_W'(NBYTES - 1);
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      shift_q <= shift_q << BYTE_W;
      if (cnt_q == '0) begin
        tx_valid <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign tx_data = shift_q[SW-1 -: BYTE_W];
  assign last_c  = (cnt_q == '0);

endmodule

// File: rtl/regfile_debug_dumper.sv
// Walks the register-file debug port x0..xN-1 and streams every word out byte-wise.
// Define DUMPER_INDEX_HEADER_EN to prefix each register with an index header byte.
module regfile_debug_dumper
  import regfile_debug_dumper_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [SEL_W-1:0]  dbg_sel,
  input  logic [WIDTH-1:0]  dbg_data,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  if ((WIDTH % BYTE_W) != 0 || WIDTH == 0) begin : g_width_chk
    $error("regfile_debug_dumper: WIDTH must be a non-zero multiple of 8");
  end
  if (NUM_REGS > 32 || NUM_REGS == 0) begin : g_regs_chk
    $error("regfile_debug_dumper: NUM_REGS must be in 1..32");
  end

`ifdef DUMPER_INDEX_HEADER_EN
  localparam int unsigned HDR_BYTES = 1;
`else
  localparam int unsigned HDR_BYTES = 0;
`endif
  localparam int unsigned NBYTES   = bytes_per_reg(WIDTH) + HDR_BYTES;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

  state_t                     state;
  logic [SEL_W-1:0]           idx;
  logic [NBYTES*BYTE_W-1:0]   load_word_c;
  logic                       last_c;

  // Header (when enabled) rides in front of the data so capture stays at the SEL exit edge
`ifdef DUMPER_INDEX_HEADER_EN
  assign load_word_c = {header_byte(idx), dbg_data};
`else
  assign load_word_c = dbg_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_SEL;
          end
        end
        ST_SEL: state <= ST_SEND;
        ST_SEND: begin
          if (tx_valid && tx_ready && last_c) begin
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              idx   <= idx + SEL_W'(1);
              state <= ST_SEL;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_sel = idx;

  regfile_debug_dumper_byte_serializer #(.NBYTES(NBYTES)) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (state == ST_SEL),
    .load_data (load_word_c),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .last_c    (last_c)
  );

endmodule

// File: tb/tb_regfile_debug_dumper.sv
// Directed bench for regfile_debug_dumper with a behavioural register file on the debug port.
module tb_regfile_debug_dumper;

`ifdef DUMPER_INDEX_HEADER_EN
  localparam int NB       = 5;
  localparam int DUMP_CYC = 192;
`else
  localparam int NB       = 4;
  localparam int DUMP_CYC = 160;
`endif
  localparam int TOTAL = 32 * NB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, tx_valid;
  logic        tx_ready = 1'b1;
  logic [4:0]  dbg_sel;
  logic [31:0] dbg_data;
  logic [7:0]  tx_data;

  logic [31:0] rf [32];
  logic [7:0]  got_q [$];
  logic [7:0]  exp_q [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;
  int          stab_err = 0;
  bit          rand_ready = 1'b0;
  bit          hold_prev = 1'b0;
  logic [7:0]  data_prev = 8'h00;

  assign dbg_data = rf[dbg_sel];

  always #5 clk = ~clk;

  regfile_debug_dumper dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  // Stream monitor: collects accepted bytes, done pulses and hold-stability violations
  always @(posedge clk) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && (!tx_valid || tx_data !== data_prev)) stab_err++;
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (done) done_cnt++;
      hold_prev = tx_valid && !tx_ready;
      data_prev = tx_data;
    end
  end

  always @(negedge clk) tx_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_expected();
    exp_q.delete();
    for (int r = 0; r < 32; r++) begin
`ifdef DUMPER_INDEX_HEADER_EN
      exp_q.push_back(8'(r));
`endif
      for (int b = 3; b >= 0; b--) exp_q.push_back(rf[r][b*8 +: 8]);
    end
  endtask

  task automatic preload();
    for (int r = 0; r < 32; r++) rf[r] = 32'hA0B0C000 + 32'(r);
  endtask

  // Runs one full dump; optional hooks poke start during x5 and overwrite x3 while it is in flight
  task automatic run_dump(input string tag, input bit hook5, input bit hook3);
    int n;
    bit poked;
    n = 0;
    poked = 1'b0;
    got_q.delete();
    done_cnt = 0;
    stab_err = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_sel"}, 32'(busy), 32'd1);
    chk({tag, "_valid_sel"}, 32'(tx_valid), 32'd0);
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == 1) begin
        chk({tag, "_valid_lat"}, 32'(tx_valid), 32'd1);
        chk({tag, "_first_byte"}, 32'(tx_data), 32'(exp_q[0]));
      end
      if (hook5 && !poked && dbg_sel == 5'd5 && tx_valid) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (hook3 && dbg_sel == 5'd3 && tx_valid) rf[3] = 32'hDEADBEEF;
    end while (!done && n < 4000);
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    if (!rand_ready) chk({tag, "_cycles"}, 32'(n), 32'(DUMP_CYC));
    if (hook5) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(TOTAL));
    chk({tag, "_stable"}, 32'(stab_err), 32'd0);
    for (int i = 0; i < TOTAL && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    logic [7:0] head [10];
    int n;
    preload();
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_sel", 32'(dbg_sel), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: ready tied high, hand-computed head and tail bytes
    build_expected();
    run_dump("t1", 1'b0, 1'b0);
`ifdef DUMPER_INDEX_HEADER_EN
    head = '{8'h00, 8'hA0, 8'hB0, 8'hC0, 8'h00, 8'h01, 8'hA0, 8'hB0, 8'hC0, 8'h01};
    for (int i = 0; i < 10; i++) chk($sformatf("t6_head%0d", i), 32'(got_q[i]), 32'(head[i]));
`else
    head = '{8'hA0, 8'hB0, 8'hC0, 8'h00, 8'hA0, 8'hB0, 8'hC0, 8'h1F, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) chk($sformatf("t1_head%0d", i), 32'(got_q[i]), 32'(head[i]));
    for (int i = 0; i < 4; i++) chk($sformatf("t1_tail%0d", i), 32'(got_q[TOTAL-4+i]), 32'(head[4+i]));
`endif

    // 2: sparse random ready
    rand_ready = 1'b1;
    run_dump("t2", 1'b0, 1'b0);
    rand_ready = 1'b0;
    @(negedge clk);

    // 3: start pokes during SEND of x5 and in DONE are ignored
    run_dump("t3", 1'b1, 1'b0);

    // 4: reset while byte 2 of x12 is on the stream
    got_q.delete();
    done_cnt = 0;
    n = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (got_q.size() < 12 * NB + 1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("t4_sel12", 32'(dbg_sel), 32'd12);
    reset = 1'b1;
    #1;
    chk("t4_valid_async", 32'(tx_valid), 32'd0);
    chk("t4_busy_async", 32'(busy), 32'd0);
    chk("t4_sel_async", 32'(dbg_sel), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_no_done", 32'(done_cnt), 32'd0);
    run_dump("t4r", 1'b0, 1'b0);

    // 5: overwrite x3 while it is in flight; old value this dump, new value next dump
    run_dump("t5a", 1'b0, 1'b1);
    build_expected();
    run_dump("t5b", 1'b0, 1'b0);
    chk("t5_x3_b0", 32'(got_q[3*NB + NB - 4]), 32'hDE);
    chk("t5_x3_b1", 32'(got_q[3*NB + NB - 3]), 32'hAD);
    chk("t5_x3_b3", 32'(got_q[3*NB + NB - 1]), 32'hEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
